// File: rtl/eth_mac_pkg.sv
// Shared types and constants for the Ethernet MAC transmit arbiter.
package eth_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } tx_state_e;

    // Beat injected when a frame is aborted: marks the frame bad towards the MAC.
    localparam logic [7:0] ABORT_TDATA = 8'h00;
    localparam logic       ABORT_TLAST = 1'b1;
    localparam logic       ABORT_TUSER = 1'b1;

endpackage

// File: rtl/eth_rr_arbiter.sv
// Combinational round-robin search: first requester after last_i, with wrap.
module eth_rr_arbiter #(
    parameter  int PORTS = 4,
    localparam int IDX_W = $clog2(PORTS)
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [PORTS-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = IDX_W'((int'(last_i) + k) % PORTS);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/eth_mac_tx_arb.sv
// Frame-level round-robin arbiter of PORTS byte streams onto one MAC tx_axis port.
// state  | meaning
// IDLE   | arbitrate among enabled, valid ports
// ACTIVE | forward granted port's frame through the output register
// DRAIN  | frame aborted on stall; discard granted port's beats up to tlast
module eth_mac_tx_arb
    import eth_mac_pkg::*;
#(
    parameter  int PORTS         = 4,
    parameter  int STALL_TIMEOUT = 16,
    localparam int IDX_W         = $clog2(PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PORTS*8-1:0]   s_axis_tdata,
    input  logic [PORTS-1:0]     s_axis_tvalid,
    input  logic [PORTS-1:0]     s_axis_tlast,
    input  logic [PORTS-1:0]     s_axis_tuser,
    output logic [PORTS-1:0]     s_axis_tready,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    input  logic                 m_axis_tready,
    input  logic [PORTS-1:0]     cfg_port_enable,
    output logic [IDX_W-1:0]     stat_grant_index,
    output logic                 stat_busy,
    output logic                 stat_frame_abort
);

    localparam int              CNT_W   = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);

    tx_state_e        state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d, last_q, last_d;
    logic [PORTS-1:0] grant_oh_q, grant_oh_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [7:0]       tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic             abort_q, abort_d;

    logic [PORTS-1:0] arb_req, arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;
    logic             can_accept, abort_now, beat_acc;
    logic             src_valid, src_last, src_user;
    logic [7:0]       src_data;

    assign arb_req = s_axis_tvalid & cfg_port_enable;

    eth_rr_arbiter #(.PORTS(PORTS)) u_arb (
        .req_i   (arb_req),
        .last_i  (last_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign can_accept = !tvalid_q || m_axis_tready;
    assign src_valid  = s_axis_tvalid[grant_q];
    assign src_last   = s_axis_tlast[grant_q];
    assign src_user   = s_axis_tuser[grant_q];
    assign src_data   = s_axis_tdata[{grant_q, 3'b000} +: 8];
    assign abort_now  = (STALL_TIMEOUT != 0) && (state_q == ST_ACTIVE)
                        && (stall_q == CNT_MAX) && can_accept;

    // The abort cycle withholds tready so a beat arriving at the timeout is not lost.
    always_comb begin
        s_axis_tready = '0;
        case (state_q)
            ST_ACTIVE: if (can_accept && !abort_now) s_axis_tready = grant_oh_q;
            ST_DRAIN:  s_axis_tready = grant_oh_q;
            default:   s_axis_tready = '0;
        endcase
    end

    assign beat_acc = src_valid && s_axis_tready[grant_q];

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        last_d     = last_q;
        stall_d    = stall_q;
        abort_d    = 1'b0;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        tuser_d    = tuser_q;
        tvalid_d   = can_accept ? 1'b0 : tvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d    = ST_ACTIVE;
                    grant_d    = arb_idx;
                    grant_oh_d = arb_grant;
                    stall_d    = '0;
                end
            end
            ST_ACTIVE: begin
                if (abort_now) begin
                    tvalid_d = 1'b1;
                    tdata_d  = ABORT_TDATA;
                    tlast_d  = ABORT_TLAST;
                    tuser_d  = ABORT_TUSER;
                    abort_d  = 1'b1;
                    stall_d  = '0;
                    state_d  = ST_DRAIN;
                end else if (beat_acc) begin
                    tvalid_d = 1'b1;
                    tdata_d  = src_data;
                    tlast_d  = src_last;
                    tuser_d  = src_user;
                    stall_d  = '0;
                    if (src_last) begin
                        state_d = ST_IDLE;
                        last_d  = grant_q;
                    end
                end else if (!src_valid && can_accept && (STALL_TIMEOUT != 0)) begin
                    stall_d = stall_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (beat_acc && src_last) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            last_q     <= IDX_W'(PORTS - 1);
            stall_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            last_q     <= last_d;
            stall_q    <= stall_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            abort_q    <= abort_d;
        end
    end

    assign m_axis_tdata     = tdata_q;
    assign m_axis_tvalid    = tvalid_q;
    assign m_axis_tlast     = tlast_q;
    assign m_axis_tuser     = tuser_q;
    assign stat_grant_index = grant_q;
    assign stat_busy        = (state_q != ST_IDLE);
    assign stat_frame_abort = abort_q;

endmodule

// File: tb/tb_eth_mac_tx_arb.sv
// Directed bench for eth_mac_tx_arb: per-port frame queues drive the sources, output beats are logged.
module tb_eth_mac_tx_arb;

    localparam int PORTS = 4;
    localparam int TMO   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [PORTS*8-1:0] s_axis_tdata;
    logic [PORTS-1:0]   s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
    logic [7:0]         m_axis_tdata;
    logic               m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic [PORTS-1:0]   cfg_port_enable;
    logic [1:0]         stat_grant_index;
    logic               stat_busy, stat_frame_abort;

    always #5 clk = ~clk;

    eth_mac_tx_arb #(.PORTS(PORTS), .STALL_TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tready    (m_axis_tready),
        .cfg_port_enable  (cfg_port_enable),
        .stat_grant_index (stat_grant_index),
        .stat_busy        (stat_busy),
        .stat_frame_abort (stat_frame_abort)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    beat_t src_q [PORTS][$];
    beat_t out_q [$];
    int    gr_q [$];
    int    acc_cyc [$];
    int    abort_cyc [$];
    int    cyc_n, n_assert, n_fail;
    logic  rand_rdy, prev_busy;

    function automatic beat_t mk(input logic [7:0] d, input logic l, input logic u);
        beat_t b;
        b.data = d;
        b.last = l;
        b.user = u;
        return b;
    endfunction

    function automatic logic all_empty();
        logic e;
        e = 1'b1;
        for (int p = 0; p < PORTS; p++) if (src_q[p].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int i, input beat_t exp);
        beat_t b;
        b = 'x;
        if (i < out_q.size()) b = out_q[i];
        chk($sformatf("%s[%0d]", tag, i), 32'(b), 32'(exp));
    endtask

    task automatic refresh();
        for (int p = 0; p < PORTS; p++) begin
            if (src_q[p].size() != 0) begin
                s_axis_tvalid[p]       = 1'b1;
                s_axis_tdata[p*8 +: 8] = src_q[p][0].data;
                s_axis_tlast[p]        = src_q[p][0].last;
                s_axis_tuser[p]        = src_q[p][0].user;
            end else begin
                s_axis_tvalid[p]       = 1'b0;
                s_axis_tdata[p*8 +: 8] = 8'h00;
                s_axis_tlast[p]        = 1'b0;
                s_axis_tuser[p]        = 1'b0;
            end
        end
    endtask

    // One clock: sample handshakes at negedge, advance sources just after posedge.
    task automatic cyc();
        logic [PORTS-1:0] acc;
        @(negedge clk);
        acc = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready)
            out_q.push_back(mk(m_axis_tdata, m_axis_tlast, m_axis_tuser));
        if (stat_frame_abort) abort_cyc.push_back(cyc_n);
        if (stat_busy && !prev_busy) gr_q.push_back(int'(stat_grant_index));
        prev_busy = stat_busy;
        @(posedge clk);
        cyc_n++;
        #1;
        for (int p = 0; p < PORTS; p++) begin
            if (acc[p]) begin
                void'(src_q[p].pop_front());
                acc_cyc.push_back(cyc_n);
            end
        end
        if (rand_rdy) m_axis_tready = ($urandom_range(0, 1) == 1);
        refresh();
        #1;
    endtask

    task automatic run_done(input string tag, input int max);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max) begin
            cyc();
            n++;
            done = !stat_busy && !m_axis_tvalid && all_empty();
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic clear_logs();
        out_q.delete();
        gr_q.delete();
        acc_cyc.delete();
        abort_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < PORTS; p++) src_q[p].delete();
        refresh();
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        int bad;
        n_assert        = 0;
        n_fail          = 0;
        cyc_n           = 0;
        rand_rdy        = 1'b0;
        prev_busy       = 1'b0;
        rst_n           = 1'b0;
        m_axis_tready   = 1'b1;
        cfg_port_enable = '1;
        s_axis_tdata    = '0;
        s_axis_tvalid   = '0;
        s_axis_tlast    = '0;
        s_axis_tuser    = '0;
        refresh();
        repeat (3) cyc();

        // reset values
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata",  32'(m_axis_tdata), 32'd0);
        chk("rst_tlast",  32'(m_axis_tlast), 32'd0);
        chk("rst_tuser",  32'(m_axis_tuser), 32'd0);
        chk("rst_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_busy",   32'(stat_busy), 32'd0);
        chk("rst_gidx",   32'(stat_grant_index), 32'd0);
        chk("rst_abort",  32'(stat_frame_abort), 32'd0);
        rst_n = 1'b1;
        cyc();

        // ports 0 and 2, 3-byte frames
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            src_q[0].push_back(mk(8'(8'hA0 + i), i == 2, 1'b0));
            src_q[2].push_back(mk(8'(8'hC0 + i), i == 2, 1'b0));
        end
        refresh();
        #1;
        chk("t2_idle_tready", 32'(s_axis_tready), 32'd0);
        cyc();
        chk("t2_busy",   32'(stat_busy), 32'd1);
        chk("t2_gidx0",  32'(stat_grant_index), 32'd0);
        chk("t2_tready", 32'(s_axis_tready), 32'h1);
        run_done("t2_done", 40);
        chk("t2_nbeats", 32'(out_q.size()), 32'd6);
        for (int i = 0; i < 3; i++) begin
            chk_beat("t2_beat", i,     mk(8'(8'hA0 + i), i == 2, 1'b0));
            chk_beat("t2_beat", i + 3, mk(8'(8'hC0 + i), i == 2, 1'b0));
        end
        chk("t2_ngrants", 32'(gr_q.size()), 32'd2);
        if (gr_q.size() == 2) begin
            chk("t2_grant_a", 32'(gr_q[0]), 32'd0);
            chk("t2_grant_b", 32'(gr_q[1]), 32'd2);
        end
        chk("t2_nacc", 32'(acc_cyc.size()), 32'd6);
        if (acc_cyc.size() == 6) chk("t2_gap", 32'(acc_cyc[3] - acc_cyc[2]), 32'd2);

        // all ports continuously valid, single-byte frames
        do_reset();
        clear_logs();
        for (int p = 0; p < PORTS; p++)
            for (int k = 0; k < 4; k++) src_q[p].push_back(mk(8'(p * 16 + k), 1'b1, 1'b0));
        refresh();
        run_done("t3_done", 100);
        chk("t3_nbeats",  32'(out_q.size()), 32'd16);
        chk("t3_ngrants", 32'(gr_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk_beat("t3_beat", i, mk(8'((i % 4) * 16 + i / 4), 1'b1, 1'b0));
        bad = 0;
        for (int i = 0; i < gr_q.size(); i++) if (gr_q[i] != i % 4) bad++;
        chk("t3_grant_order", 32'(bad), 32'd0);
        bad = 0;
        for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] - acc_cyc[i-1] != 2) bad++;
        chk("t3_frame_spacing", 32'(bad), 32'd0);

        // 64-byte frame with random output backpressure; tuser beat passes through
        clear_logs();
        rand_rdy = 1'b1;
        for (int i = 0; i < 64; i++) src_q[1].push_back(mk(8'(i), i == 63, i == 10));
        refresh();
        run_done("t4_done", 600);
        rand_rdy      = 1'b0;
        m_axis_tready = 1'b1;
        chk("t4_nbeats", 32'(out_q.size()), 32'd64);
        for (int i = 0; i < 64; i++) chk_beat("t4_beat", i, mk(8'(i), i == 63, i == 10));

        // port 1 stalls after 5 bytes -> abort beat, rest discarded
        clear_logs();
        for (int i = 0; i < 5; i++) src_q[1].push_back(mk(8'(8'h50 + i), 1'b0, 1'b0));
        refresh();
        repeat (40) cyc();
        chk("t5_abort_cnt", 32'(abort_cyc.size()), 32'd1);
        chk("t5_nacc", 32'(acc_cyc.size()), 32'd5);
        if (abort_cyc.size() == 1 && acc_cyc.size() == 5)
            chk("t5_abort_delay", 32'(abort_cyc[0] - acc_cyc[4]), 32'd17);
        chk("t5_drain_busy",   32'(stat_busy), 32'd1);
        chk("t5_drain_tready", 32'(s_axis_tready), 32'h2);
        chk("t5_nbeats", 32'(out_q.size()), 32'd6);
        for (int i = 0; i < 5; i++) chk_beat("t5_beat", i, mk(8'(8'h50 + i), 1'b0, 1'b0));
        chk_beat("t5_abort_beat", 5, mk(8'h00, 1'b1, 1'b1));
        for (int i = 0; i < 5; i++) src_q[1].push_back(mk(8'(8'h55 + i), i == 4, 1'b0));
        refresh();
        run_done("t5_done", 30);
        chk("t5_nbeats_after", 32'(out_q.size()), 32'd6);
        chk("t5_abort_cnt_after", 32'(abort_cyc.size()), 32'd1);

        // port 0 disabled, then enabled and disabled mid-frame
        clear_logs();
        cfg_port_enable = 4'b1110;
        for (int i = 0; i < 4; i++) src_q[0].push_back(mk(8'(8'h10 + i), i == 3, 1'b0));
        for (int i = 0; i < 2; i++) src_q[3].push_back(mk(8'(8'h30 + i), i == 1, 1'b0));
        refresh();
        repeat (20) cyc();
        chk("t6_nbeats_dis", 32'(out_q.size()), 32'd2);
        chk("t6_p0_pending", 32'(src_q[0].size()), 32'd4);
        chk("t6_ngrants_dis", 32'(gr_q.size()), 32'd1);
        for (int i = 0; i < 2; i++) chk_beat("t6_beat", i, mk(8'(8'h30 + i), i == 1, 1'b0));
        cfg_port_enable = 4'b1111;
        repeat (2) cyc();
        cfg_port_enable = 4'b1110;
        run_done("t6_done", 30);
        chk("t6_nbeats", 32'(out_q.size()), 32'd6);
        for (int i = 0; i < 4; i++) chk_beat("t6_beat", i + 2, mk(8'(8'h10 + i), i == 3, 1'b0));
        chk("t6_ngrants", 32'(gr_q.size()), 32'd2);
        if (gr_q.size() == 2) chk("t6_grant_p0", 32'(gr_q[1]), 32'd0);
        cfg_port_enable = 4'b1111;

        // reset mid-frame
        clear_logs();
        for (int i = 0; i < 6; i++) src_q[2].push_back(mk(8'(8'hC0 + i), i == 5, 1'b0));
        refresh();
        repeat (5) cyc();
        chk("t7_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("t7_pre_tdata",  32'(m_axis_tdata), 32'hC3);
        rst_n = 1'b0;
        #1;
        chk("t7_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("t7_tdata",  32'(m_axis_tdata), 32'd0);
        chk("t7_tlast",  32'(m_axis_tlast), 32'd0);
        chk("t7_tuser",  32'(m_axis_tuser), 32'd0);
        chk("t7_tready", 32'(s_axis_tready), 32'd0);
        chk("t7_busy",   32'(stat_busy), 32'd0);
        chk("t7_gidx",   32'(stat_grant_index), 32'd0);
        chk("t7_abort",  32'(stat_frame_abort), 32'd0);
        for (int p = 0; p < PORTS; p++) src_q[p].delete();
        refresh();
        repeat (2) cyc();
        clear_logs();
        rst_n = 1'b1;
        src_q[3].push_back(mk(8'h3F, 1'b1, 1'b0));
        src_q[0].push_back(mk(8'h0F, 1'b1, 1'b0));
        refresh();
        run_done("t7_done", 30);
        chk("t7_ngrants", 32'(gr_q.size()), 32'd2);
        if (gr_q.size() == 2) begin
            chk("t7_first_grant",  32'(gr_q[0]), 32'd0);
            chk("t7_second_grant", 32'(gr_q[1]), 32'd3);
        end
        chk("t7_nbeats", 32'(out_q.size()), 32'd2);
        chk_beat("t7_beat", 0, mk(8'h0F, 1'b1, 1'b0));
        chk_beat("t7_beat", 1, mk(8'h3F, 1'b1, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
